// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, FSM encoding and GF(2^8) constant multipliers.
package aes_pkg;
  typedef logic [31:0] word_t;
  typedef logic [127:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  localparam logic [7:0] AES_POLY = 8'h1B;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] gmul_9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction
  function automatic logic [7:0] gmul_b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction
  function automatic logic [7:0] gmul_d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction
  function automatic logic [7:0] gmul_e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction
endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// inv_mix_columns_seq_if: start/state handshake and result bus of the InvMixColumns stage.
interface inv_mix_columns_seq_if;
  logic start;
  aes_pkg::state_t state_in;
  logic busy;
  logic done;
  logic [1:0] word_sel;
  aes_pkg::state_t state_out;
  modport master(output start, state_in, input busy, done, word_sel, state_out);
  modport slave(input start, state_in, output busy, done, word_sel, state_out);
endinterface

// File: rtl/inv_mix_word.sv
// inv_mix_word: combinational InvMixColumns of one 32-bit column (row 0 in bits 31:24).
module inv_mix_word
  import aes_pkg::*;
(
  input  word_t col_in,
  output word_t col_out
);
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_in;
  assign col_out = {gmul_e(a0) ^ gmul_b(a1) ^ gmul_d(a2) ^ gmul_9(a3),
                    gmul_9(a0) ^ gmul_e(a1) ^ gmul_b(a2) ^ gmul_d(a3),
                    gmul_d(a0) ^ gmul_9(a1) ^ gmul_e(a2) ^ gmul_b(a3),
                    gmul_b(a0) ^ gmul_d(a1) ^ gmul_9(a2) ^ gmul_e(a3)};
endmodule

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: word-serial InvMixColumns, one column per cycle through a shared column unit.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input logic CLK,
  input logic RESET_N,
  inv_mix_columns_seq_if.slave bus
);
  fsm_t state, state_nx;
  state_t cap, result;
  logic [1:0] word_sel;
  logic [6:0] lsb;
  logic accept;
  word_t col_out;
  // word k lives at bits [127-32k -: 32], i.e. LSB offset 32*(3-k)
  assign lsb = {~word_sel, 5'b0};
  assign accept = bus.start && state != RUN;
  inv_mix_word u_mix (.col_in(cap[lsb +: 32]), .col_out(col_out));
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == RUN) ? ((word_sel == 2'd3) ? DONE : RUN) : (bus.start ? RUN : IDLE);
  always_comb begin
    bus.busy = state == RUN;
    bus.done = state == DONE;
    bus.word_sel = word_sel;
    bus.state_out = result;
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      cap <= '0;
      result <= '0;
      word_sel <= 2'd0;
    end else if (accept) begin
      cap <= bus.state_in;
      word_sel <= 2'd0;
    end else if (state == RUN) begin
      result[lsb +: 32] <= col_out;
      word_sel <= word_sel + 2'd1;
    end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: table vectors, random ops against a GF(2^8) matrix model, and corner sequences.
module tb_inv_mix_columns_seq;
  import aes_pkg::*;
  typedef struct { state_t in; state_t exp; } vec_t;
  logic clk = 0, rst_n = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  inv_mix_columns_seq_if bus();
  inv_mix_columns_seq dut (.CLK(clk), .RESET_N(rst_n), .bus(bus));

  task automatic chk(input string name, input state_t got, input state_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic state_t imc_ref(input state_t s);
    logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0] a [16];
    logic [7:0] acc;
    state_t res = '0;
    for (int i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gf_mul(coef[(j - r + 4) % 4], a[4*c + j]);
        res[127 - 8*(4*c + r) -: 8] = acc;
      end
    return res;
  endfunction

  function automatic state_t rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_op(input state_t in, input bit poke, input string name);
    int n, nb;
    logic [7:0] ws;
    bus.state_in = in;
    bus.start = 1;
    tick;
    bus.start = 0;
    n = 1; nb = 0; ws = 8'h00;
    while (!bus.done && n < 12) begin
      ws = {ws[5:0], bus.word_sel};
      nb += int'(bus.busy);
      if (poke && n == 2) begin
        bus.start = 1;
        bus.state_in = ~in;
      end else bus.start = 0;
      tick;
      n++;
    end
    bus.start = 0;
    chk({name, " latency"}, 128'(n - 1), 128'(4));
    chk({name, " word_sel seq"}, 128'(ws), 128'(8'h1b));
    chk({name, " busy cycles"}, 128'(nb), 128'(4));
    chk({name, " busy at done"}, 128'(bus.busy), 128'(0));
    chk({name, " result"}, bus.state_out, imc_ref(in));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [3];
    state_t ra, rb, prev;
    int n;
    vecs[0] = '{in: {4{32'h8e4da1bc}}, exp: {4{32'hdb135345}}};
    vecs[1] = '{in: 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6,
                exp: 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5};
    vecs[2] = '{in: {4{32'h4d7ebdf8}}, exp: {4{32'h2d26314c}}};
    bus.start = 0;
    bus.state_in = '0;
    tick; tick;
    chk("reset busy", 128'(bus.busy), 128'(0));
    chk("reset done", 128'(bus.done), 128'(0));
    chk("reset word_sel", 128'(bus.word_sel), 128'(0));
    chk("reset state_out", bus.state_out, '0);
    rst_n = 1;
    tick;
    for (int i = 0; i < 3; i++) begin
      run_op(vecs[i].in, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table", i), bus.state_out, vecs[i].exp);
      tick;
    end
    for (int i = 0; i < 12; i++) begin
      run_op(rand_state(), 0, $sformatf("rnd%0d", i));
      if (i % 2 == 1) tick;
    end
    tick;
    run_op(128'h0123456789abcdef_fedcba9876543210, 1, "busy protect");
    tick;
    ra = imc_ref({4{32'h8e4da1bc}});
    rb = imc_ref({4{32'h4d7ebdf8}});
    run_op({4{32'h8e4da1bc}}, 0, "b2b first");
    bus.state_in = {4{32'h4d7ebdf8}};
    bus.start = 1;
    tick;
    bus.start = 0;
    bus.state_in = rand_state();
    chk("b2b hold first", bus.state_out, ra);
    chk("b2b busy", 128'(bus.busy), 128'(1));
    tick;
    chk("b2b word0", bus.state_out, {rb[127:96], ra[95:0]});
    n = 2;
    while (!bus.done && n < 12) begin
      tick;
      n++;
    end
    chk("b2b latency", 128'(n - 1), 128'(4));
    chk("b2b result", bus.state_out, {4{32'h2d26314c}});
    prev = bus.state_out;
    for (int i = 0; i < 10; i++) begin
      bus.state_in = rand_state();
      tick;
      chk($sformatf("hold out %0d", i), bus.state_out, prev);
      chk($sformatf("hold busy %0d", i), 128'(bus.busy), 128'(0));
    end
    bus.state_in = rand_state();
    bus.start = 1;
    tick;
    bus.start = 0;
    tick; tick;
    #2 rst_n = 0;
    #1;
    chk("midrun rst busy", 128'(bus.busy), 128'(0));
    chk("midrun rst done", 128'(bus.done), 128'(0));
    chk("midrun rst word_sel", 128'(bus.word_sel), 128'(0));
    chk("midrun rst state_out", bus.state_out, '0);
    tick;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("post rst done %0d", i), 128'(bus.done), 128'(0));
      chk($sformatf("post rst busy %0d", i), 128'(bus.busy), 128'(0));
    end
    run_op(rand_state(), 0, "after reset");
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Word-serial InvMixColumns stage for the AES decryption datapath. It captures a 128-bit state and applies the InvMixColumns transform to one 32-bit column per cycle through a single shared GF(2^8) column unit. It writes each result word into an output state register, using the same word-select convention as the datapath's word multiplexer and collector. The block sits between the round-key-add stage and the next inverse shift-rows/sub-bytes step.

## Interface
- No parameters; the state width is fixed at 128 and the word width at 32.
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous, active-low reset
- start  input  1  request to begin; sampled only while busy=0
- state_in  input  128  state to transform; captured on the accepting edge
- busy  output  1  high while columns are being processed
- done  output  1  one-cycle pulse; state_out is complete
- word_sel  output  2  index of the column in progress (0 = bits 127:96, 3 = bits 31:0)
- state_out  output  128  transformed state; held stable until the next accepted start

## Operation
- Reset is asynchronous and active-low.
  - Reset values: FSM=IDLE, busy=0, done=0, word_sel=0, state_out=0, capture register=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → capture state_in, word_sel←0, go to RUN.
  - RUN: each cycle, write col_out(word_sel) into the state_out word chosen by word_sel, then increment word_sel.
    - When word_sel=3, after the write go to DONE; word_sel wraps to 0.
  - DONE: done=1, busy=0, for exactly one cycle.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- start while busy=1 is ignored; state_in changes during RUN have no effect.
- Word mapping: index k selects bits [127-32k : 96-32k].
- Column byte order: bits [31:24] = row 0, [7:0] = row 3.
- InvMixColumns per column, arithmetic in GF(2^8) modulo x^8+x^4+x^3+x+1:
  - r0 = 0e·a0 ⊕ 0b·a1 ⊕ 0d·a2 ⊕ 09·a3
  - the coefficients rotate right by one position per row.
- Multiplication uses xtime chains: ×9, ×b, ×d and ×e are built from ×2, ×4 and ×8 by XOR.
- All results are 8 bits; no carries are kept.
- state_out words not yet written during RUN hold their previous values.
- Reset asserted mid-operation aborts immediately to reset values; no done is produced.

## Timing
- Accepting edge E0 is the CLK edge with start=1 and busy=0.
- busy=1 in the cycles after E0, E1, E2 and E3.
- Word k is written to state_out at edge E(k+1).
- done=1 and busy=0 in the cycle after E4.
- Latency from accepting edge to done: 4 cycles.
- Back-to-back throughput: one state per 5 cycles.
- word_sel equals k during the cycle before edge E(k+1).
- The column unit is purely combinational between registers, giving one GF stage per cycle.
- No combinational path from start to any output.

## Structure
- Shared package aes_pkg holds:
  - typedef word_t (logic [31:0])
  - typedef state_t (logic [127:0])
  - the FSM state enum
  - constant AES_POLY = 8'h1B
  - functions xtime and gmul for constants 9, b, d, e
- Sub-module inv_mix_word: combinational, 32-bit column in → 32-bit column out, implemented with the aes_pkg functions.
  - It is instantiated once here and is reusable by a future fully parallel variant.

## Test plan
- Reset: hold RESET_N=0 mid-RUN → all outputs 0 immediately. Release, idle 3 cycles → done never pulses.
- Single column check: state_in = 32'h8e4da1bc repeated in all four words → state_out = {4{32'hdb135345}} and done exactly 4 cycles after the accepting edge.
- Mixed columns:
  - stimulus state_in = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6
  - required state_out = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5
  - word_sel steps 0,1,2,3 in order.
- Busy protection: pulse start with a different state_in during RUN → ignored; result matches the first operation.
- Back-to-back:
  - assert start in the DONE cycle with state_in = 128'h4d7ebdf8 repeated
  - second done follows 4 cycles later
  - state_out = {4{32'h2d26314c}}
  - state_out holds the first result until the second operation's word 0 write.
- Hold: after done, toggle state_in randomly for 10 cycles with start=0 → state_out unchanged and busy=0.
